// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package demux_pkg;
    localparam int NUM_CH  = 4;
    localparam int SEL_W   = 2;
    localparam int COUNT_W = 16;

    typedef logic [SEL_W-1:0] ch_sel_t;
endpackage

// File: rtl/demux_slot.sv
// One-entry channel slot: loads a word on load, empties on take, and stays full when both happen together.
module demux_slot #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 take,
    input  logic [BIT_WIDTH-1:0] din,
    output logic                 valid,
    output logic [BIT_WIDTH-1:0] dout
);

    logic                 vld_p0;
    logic [BIT_WIDTH-1:0] data_p0;

    // slot register stage; load wins over take so a same-cycle refill stays full
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else if (load) begin
            vld_p0  <= 1'b1;
            data_p0 <= din;
        end else if (take) begin
            vld_p0  <= 1'b0;
        end
    end

    assign valid = vld_p0;
    assign dout  = data_p0;

endmodule

// File: rtl/demux1to4.sv
// Registered 1-to-4 valid/ready demultiplexer with independent per-channel back-pressure.
// Optional stall counter output drop_count is built when DEMUX1TO4_COUNT_EN is defined.
module demux1to4
    import demux_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_select,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]    out_valid,
    input  logic [NUM_CH-1:0]    out_ready,
    output logic [BIT_WIDTH-1:0] out0,
    output logic [BIT_WIDTH-1:0] out1,
    output logic [BIT_WIDTH-1:0] out2,
    output logic [BIT_WIDTH-1:0] out3
`ifdef DEMUX1TO4_COUNT_EN
    ,
    output logic [COUNT_W-1:0]   drop_count
`endif
);

    ch_sel_t              sel;
    logic                 accept;
    logic [NUM_CH-1:0]    load;
    logic [NUM_CH-1:0]    take;
    logic [BIT_WIDTH-1:0] slot_data [NUM_CH];

    assign sel = in_select;

    // Readiness looks only at the addressed channel, so a stalled slot never blocks the others.
    assign in_ready = !out_valid[sel] | out_ready[sel];
    assign accept   = in_valid & in_ready;
    assign take     = out_valid & out_ready;

    always_comb begin
        load      = '0;
        load[sel] = accept;
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_slot
        demux_slot #(
            .BIT_WIDTH(BIT_WIDTH)
        ) u_slot (
            .clk   (clk),
            .reset (reset),
            .load  (load[n]),
            .take  (take[n]),
            .din   (in_data),
            .valid (out_valid[n]),
            .dout  (slot_data[n])
        );
    end

    assign out0 = slot_data[0];
    assign out1 = slot_data[1];
    assign out2 = slot_data[2];
    assign out3 = slot_data[3];

`ifdef DEMUX1TO4_COUNT_EN
    logic [COUNT_W-1:0] drop_cnt_p0;

    // stall counter stage, saturating at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_p0 <= '0;
        end else if (in_valid && !in_ready && (drop_cnt_p0 != '1)) begin
            drop_cnt_p0 <= drop_cnt_p0 + 1'b1;
        end
    end

    assign drop_count = drop_cnt_p0;
`endif

endmodule

// File: tb/tb_demux1to4.sv
// Directed self-checking bench for demux1to4 (drop_count checks compiled in with DEMUX1TO4_COUNT_EN).
module tb_demux1to4;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_select;
    logic [W-1:0] in_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [W-1:0] out0, out1, out2, out3;
`ifdef DEMUX1TO4_COUNT_EN
    logic [15:0]  drop_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux1to4 #(.BIT_WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_select  (in_select),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3)
`ifdef DEMUX1TO4_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock edge and settle 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_select = 2'd0;
        in_data   = '0;
        out_ready = 4'b0000;

        // reset held two cycles, then idle
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_out0", 64'(out0), 64'h0);
        check("rst_out1", 64'(out1), 64'h0);
        check("rst_out2", 64'(out2), 64'h0);
        check("rst_out3", 64'(out3), 64'h0);
        for (int s = 0; s < 4; s++) begin
            in_select = 2'(s);
            #1;
            check($sformatf("rst_ready_sel%0d", s), 64'(in_ready), 64'h1);
        end
`ifdef DEMUX1TO4_COUNT_EN
        check("rst_drop", 64'(drop_count), 64'h0);
`endif

        // single route to channel 2
        in_select = 2'd2;
        in_data   = 32'hA5A5_0001;
        in_valid  = 1'b1;
        #1;
        check("route_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        check("route_valid", 64'(out_valid), 64'h4);
        check("route_out2", 64'(out2), 64'hA5A5_0001);
        check("route_out0", 64'(out0), 64'h0);
        check("route_out1", 64'(out1), 64'h0);
        check("route_out3", 64'(out3), 64'h0);
        #1;
        check("route_ready_full", 64'(in_ready), 64'h0);
        in_select = 2'd0;
        #1;
        check("route_ready_other", 64'(in_ready), 64'h1);

        // channel 2 stalled; channels 0,1,3 must still accept back-to-back
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_select = (i == 2) ? 2'd3 : 2'(i);
            in_data   = 32'h11 * (i + 1);
            #1;
            check($sformatf("indep_ready%0d", i), 64'(in_ready), 64'h1);
            tick();
        end
        in_valid = 1'b0;
        check("indep_valid", 64'(out_valid), 64'hF);
        check("indep_out0", 64'(out0), 64'h11);
        check("indep_out1", 64'(out1), 64'h22);
        check("indep_out3", 64'(out3), 64'h33);
        check("indep_out2_hold", 64'(out2), 64'hA5A5_0001);

        // stream 1..8 into channel 1 with its consumer always ready
        out_ready = 4'b0010;
        in_valid  = 1'b1;
        in_select = 2'd1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 32'(i);
            #1;
            check($sformatf("stream_ready%0d", i), 64'(in_ready), 64'h1);
            tick();
            check($sformatf("stream_out1_%0d", i), 64'(out1), 64'(i));
            check($sformatf("stream_vld_%0d", i), 64'(out_valid[1]), 64'h1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain", 64'(out_valid), 64'hD);
        out_ready = 4'b0000;

        // channel 0: replace with DEAD, then same-cycle take + load of BEEF
        out_ready = 4'b0001;
        in_select = 2'd0;
        in_data   = 32'hDEAD;
        in_valid  = 1'b1;
        tick();
        check("tl_dead", 64'(out0), 64'hDEAD);
        in_data = 32'hBEEF;
        #1;
        check("tl_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        check("tl_valid0", 64'(out_valid[0]), 64'h1);
        check("tl_out0", 64'(out0), 64'hBEEF);
        tick();
        check("tl_hold0", 64'(out0), 64'hBEEF);
        check("tl_hold_valid", 64'(out_valid), 64'hD);

        // channel 3 stalled: hold a request on it for 5 cycles
        in_select = 2'd3;
        in_data   = 32'h9999;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("stall_ready%0d", i), 64'(in_ready), 64'h0);
            tick();
        end
        in_valid = 1'b0;
        check("stall_out3", 64'(out3), 64'h33);
        check("stall_valid", 64'(out_valid), 64'hD);
`ifdef DEMUX1TO4_COUNT_EN
        check("drop_5", 64'(drop_count), 64'h5);
`endif

        // reset mid-operation with accept and takes pending; both discarded
        reset     = 1'b1;
        out_ready = 4'b1111;
        in_select = 2'd0;
        in_data   = 32'h1234;
        in_valid  = 1'b1;
        tick();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        check("mid_rst_valid", 64'(out_valid), 64'h0);
        check("mid_rst_out0", 64'(out0), 64'h0);
        check("mid_rst_out1", 64'(out1), 64'h0);
        check("mid_rst_out3", 64'(out3), 64'h0);
`ifdef DEMUX1TO4_COUNT_EN
        check("mid_rst_drop", 64'(drop_count), 64'h0);
`endif

        // normal routing resumes after reset
        in_select = 2'd1;
        in_data   = 32'h77;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_rst_valid", 64'(out_valid), 64'h2);
        check("post_rst_out1", 64'(out1), 64'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
